// File: rtl/urv_fetch.sv
// uRV instruction fetch stage: drives instruction memory, tracks the fetch PC,
// applies Execute redirects and presents f_ir/f_pc/f_valid to Decode.
module urv_fetch #(
    parameter logic [31:0] g_reset_vector = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        f_stall_i,
    input  logic        f_kill_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_pc_bra_i,

    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,

    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o
);

    typedef enum logic [1:0] {
        StReset,
        StBoot,
        StRun
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] f_ir_q;
    logic [31:0] f_pc_q;
    logic        f_valid_q;
    logic        advance;
    logic        accept;

    assign advance = (state_q == StRun) && im_valid_i && !f_stall_i;
    assign accept  = advance && !x_bra_i && !f_kill_i;

    // pc_q is the address whose word is on im_data_i this cycle
    always_comb begin
        if (state_q != StRun) begin
            im_addr_o = g_reset_vector;
        end else if (x_bra_i) begin
            im_addr_o = x_pc_bra_i;
        end else if (advance) begin
            im_addr_o = pc_q + 32'd4;
        end else begin
            im_addr_o = pc_q;
        end
    end

    assign im_rd_o   = (state_q != StReset);
    assign f_ir_o    = f_ir_q;
    assign f_pc_o    = f_pc_q;
    assign f_valid_o = f_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= StReset;
            pc_q      <= g_reset_vector;
            f_ir_q    <= 32'd0;
            f_pc_q    <= 32'd0;
            f_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StReset: state_q <= StBoot;
                StBoot:  state_q <= StRun;
                default: state_q <= StRun;
            endcase

            pc_q <= im_addr_o;

            // A redirect or kill clears valid even under stall
            if (x_bra_i || f_kill_i) begin
                f_valid_q <= 1'b0;
            end else if (f_stall_i) begin
                f_valid_q <= f_valid_q;
            end else if (accept) begin
                f_ir_q    <= im_data_i;
                f_pc_q    <= pc_q;
                f_valid_q <= 1'b1;
            end else begin
                f_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_urv_fetch.sv
// Randomised scoreboard bench for urv_fetch: a cycle-level reference model
// predicts the memory address and Decode outputs; a monitor compares mid-cycle.
module tb_urv_fetch;

    localparam logic [31:0] ResetVec = 32'h0000_0100;
    localparam int          NumCycles = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_stall, f_kill, x_bra;
    logic [31:0] x_pc_bra;
    logic [31:0] im_addr;
    logic        im_rd;
    logic [31:0] im_data;
    logic        im_valid;
    logic [31:0] f_ir, f_pc;
    logic        f_valid;

    always #5 clk = ~clk;

    urv_fetch #(
        .g_reset_vector(ResetVec)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .f_stall_i (f_stall),
        .f_kill_i  (f_kill),
        .x_bra_i   (x_bra),
        .x_pc_bra_i(x_pc_bra),
        .im_addr_o (im_addr),
        .im_rd_o   (im_rd),
        .im_data_i (im_data),
        .im_valid_i(im_valid),
        .f_ir_o    (f_ir),
        .f_pc_o    (f_pc),
        .f_valid_o (f_valid)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] addr_prev;

    // Memory contents are a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
    endfunction

    // The memory answers for the address presented on the previous cycle
    always @(posedge clk) addr_prev <= im_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared away from the clock edge
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("im_addr", im_addr, e.addr);
                check("im_rd", {31'd0, im_rd}, {31'd0, e.rd});
                check("f_valid", {31'd0, f_valid}, {31'd0, e.valid});
                check("f_pc", f_pc, e.pc);
                check("f_ir", f_ir, e.ir);
            end
        end
    end

    initial begin
        int          since;   // cycles since reset release, saturating at 2 (2 = running)
        logic [31:0] m_pc;
        logic        m_valid;
        logic [31:0] m_opc, m_oir;
        logic [31:0] e_addr;
        logic        acc;
        exp_t        e;

        rst_n    = 1'b0;
        f_stall  = 1'b0;
        f_kill   = 1'b0;
        x_bra    = 1'b0;
        x_pc_bra = 32'd0;
        im_valid = 1'b1;
        im_data  = 32'd0;
        repeat (2) @(posedge clk);

        since   = 0;
        m_pc    = ResetVec;
        m_valid = 1'b0;
        m_opc   = 32'd0;
        m_oir   = 32'd0;

        for (int cyc = 0; cyc < NumCycles; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 30) begin
                rst_n    = 1'b1;
                f_stall  = 1'b0;
                f_kill   = 1'b0;
                x_bra    = 1'b0;
                im_valid = 1'b1;
            end else begin
                rst_n    = ($urandom_range(99) >= 2);
                f_stall  = ($urandom_range(99) < 25);
                f_kill   = ($urandom_range(99) < 10);
                x_bra    = ($urandom_range(99) < 8);
                im_valid = ($urandom_range(99) < 80);
            end
            case ($urandom_range(3))
                0:       x_pc_bra = 32'h0000_0200;
                1:       x_pc_bra = 32'hFFFF_FFF8;
                default: x_pc_bra = $urandom & 32'hFFFF_FFFC;
            endcase
            im_data = mem_word(addr_prev);

            if (since < 2)
                e_addr = ResetVec;
            else if (x_bra)
                e_addr = x_pc_bra;
            else if (im_valid && !f_stall)
                e_addr = m_pc + 32'd4;
            else
                e_addr = m_pc;

            e.addr  = e_addr;
            e.rd    = (since >= 1);
            e.valid = m_valid;
            e.pc    = m_opc;
            e.ir    = m_oir;
            sb.push_back(e);

            if (!rst_n) begin
                since   = 0;
                m_pc    = ResetVec;
                m_valid = 1'b0;
                m_opc   = 32'd0;
                m_oir   = 32'd0;
            end else begin
                acc = (since >= 2) && im_valid && !f_stall && !x_bra && !f_kill;
                if (x_bra || f_kill) begin
                    m_valid = 1'b0;
                end else if (f_stall) begin
                    m_valid = m_valid;
                end else if (acc) begin
                    m_valid = 1'b1;
                    m_opc   = m_pc;
                    m_oir   = mem_word(m_pc);
                end else begin
                    m_valid = 1'b0;
                end
                m_pc  = e_addr;
                since = (since < 2) ? since + 1 : 2;
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
